// File: rtl/bpsk_modulator_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bpsk_modulator_top                                              |
// | Brief    : BPSK transmitter; NCO-addressed cosine LUT, per-bit sign flip.  |
// |            Option macro BPSK_MOD_DIFF_ENCODE_EN enables differential enc.  |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+

`ifndef FIXDT_64_A_WIDTH
`define FIXDT_64_A_WIDTH 16
`endif
`ifndef CARRIER_SAMPLES_PER_PERIOD
`define CARRIER_SAMPLES_PER_PERIOD 64
`endif
`ifndef SAMPLING_FREQ
`define SAMPLING_FREQ 100000000
`endif
`ifndef CARRIER_FREQ
`define CARRIER_FREQ 6250000
`endif
`ifndef SAMPLES_PER_SYMBOL
`define SAMPLES_PER_SYMBOL 8
`endif

module bpsk_modulator_top #(
  parameter int SAMPLE_W   = `FIXDT_64_A_WIDTH,
  parameter int LUT_ADDR_W = $clog2(`CARRIER_SAMPLES_PER_PERIOD),
  parameter int PHASE_STEP = `CARRIER_SAMPLES_PER_PERIOD / (`SAMPLING_FREQ / `CARRIER_FREQ),
  parameter int SPS        = `SAMPLES_PER_SYMBOL
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       bit_in,
  input  logic                       bit_valid,
  output logic                       bit_ready,
  output logic [LUT_ADDR_W-1:0]      cosine_lu_angle_steps,
  input  logic signed [SAMPLE_W-1:0] cosine_lu_value,
  output logic signed [SAMPLE_W-1:0] data_out,
  output logic                       data_out_valid,
  output logic                       underrun
);

  localparam int CNT_W = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CNT_W-1:0]           C_LAST = CNT_W'(SPS - 1);
  localparam logic [LUT_ADDR_W-1:0]      C_STEP = LUT_ADDR_W'(PHASE_STEP);
  localparam logic signed [SAMPLE_W-1:0] C_MIN  = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic signed [SAMPLE_W-1:0] C_MAX  = {1'b0, {(SAMPLE_W-1){1'b1}}};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                     r_state;
  logic [CNT_W-1:0]           r_sym_cnt;
  logic                       r_sym_bit;
  logic                       r_underrun;
  logic [LUT_ADDR_W-1:0]      r_phase_acc;
  logic                       r_active1;
  logic                       r_sym_bit1;
  logic signed [SAMPLE_W-1:0] r_data_out;
  logic                       r_data_out_valid;

  logic                       w_last;
  logic                       w_ready;
  logic                       w_accept;
  logic                       w_tx_sym;
  logic signed [SAMPLE_W-1:0] w_neg;

  assign w_last   = (r_sym_cnt == C_LAST);
  assign w_ready  = !rst && ((r_state == S_IDLE) || ((r_state == S_RUN) && w_last));
  assign w_accept = bit_valid && w_ready;

`ifdef BPSK_MOD_DIFF_ENCODE_EN
  // Reference symbol survives idle gaps and underruns; only reset clears it.
  logic r_prev_symbol;

  assign w_tx_sym = bit_in ^ r_prev_symbol;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_symbol <= 1'b0;
    end else if (w_accept) begin
      r_prev_symbol <= w_tx_sym;
    end
  end
`else
  assign w_tx_sym = bit_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sym_cnt  <= '0;
      r_sym_bit  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state   <= S_RUN;
            r_sym_cnt <= '0;
            r_sym_bit <= w_tx_sym;
          end
        end
        S_RUN: begin
          if (w_last) begin
            r_sym_cnt <= '0;
            if (w_accept) begin
              r_sym_bit <= w_tx_sym;
            end else begin
              r_state    <= S_IDLE;
              r_underrun <= 1'b1;
            end
          end else begin
            r_sym_cnt <= r_sym_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_sym_cnt <= '0;
        end
      endcase
    end
  end

  // Free-running NCO keeps the carrier phase continuous across idle gaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase_acc <= '0;
    end else begin
      r_phase_acc <= r_phase_acc + C_STEP;
    end
  end

  assign w_neg = (cosine_lu_value == C_MIN) ? C_MAX : -cosine_lu_value;

  // Stage 1 tracks the LUT's registered latency; stage 2 applies the sign.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active1        <= 1'b0;
      r_sym_bit1       <= 1'b0;
      r_data_out       <= '0;
      r_data_out_valid <= 1'b0;
    end else begin
      r_active1        <= (r_state == S_RUN);
      r_sym_bit1       <= r_sym_bit;
      r_data_out_valid <= r_active1;
      if (r_active1) begin
        r_data_out <= r_sym_bit1 ? w_neg : cosine_lu_value;
      end else begin
        r_data_out <= '0;
      end
    end
  end

  assign bit_ready             = w_ready;
  assign cosine_lu_angle_steps = r_phase_acc;
  assign data_out              = r_data_out;
  assign data_out_valid        = r_data_out_valid;
  assign underrun              = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_bpsk_modulator_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_bpsk_modulator_top                                           |
// | Brief    : Directed self-checking bench with a registered cosine LUT stub. |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+

module tb_bpsk_modulator_top;

  localparam int SW   = 16;
  localparam int AW   = 6;
  localparam int STEP = 4;
  localparam int SPS  = 8;
  localparam logic signed [SW-1:0] C_MIN = 16'sh8000;
  localparam logic signed [SW-1:0] C_MAX = 16'sh7FFF;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 bit_in;
  logic                 bit_valid;
  logic                 bit_ready;
  logic [AW-1:0]        cosine_lu_angle_steps;
  logic signed [SW-1:0] cosine_lu_value;
  logic signed [SW-1:0] data_out;
  logic                 data_out_valid;
  logic                 underrun;

  logic                 force_min;
  logic [AW-1:0]        exp_phase;
  logic [AW-1:0]        ph1;
  logic [AW-1:0]        ph2;
  logic                 prev_model;
  int                   vectors;
  int                   fails;

  bpsk_modulator_top #(
    .SAMPLE_W   (SW),
    .LUT_ADDR_W (AW),
    .PHASE_STEP (STEP),
    .SPS        (SPS)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .bit_in                (bit_in),
    .bit_valid             (bit_valid),
    .bit_ready             (bit_ready),
    .cosine_lu_angle_steps (cosine_lu_angle_steps),
    .cosine_lu_value       (cosine_lu_value),
    .data_out              (data_out),
    .data_out_valid        (data_out_valid),
    .underrun              (underrun)
  );

  always #5 clk = ~clk;

  // Distinct, never-zero ramp so every sample value identifies its angle.
  function automatic logic signed [SW-1:0] lut_f(input logic [AW-1:0] a);
    return SW'(int'(a) * 1000 - 31500);
  endfunction

  always @(posedge clk) begin
    cosine_lu_value <= force_min ? C_MIN : lut_f(cosine_lu_angle_steps);
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    logic r;
    r   = rst;
    ph2 = ph1;
    ph1 = exp_phase;
    @(posedge clk);
    #1;
    exp_phase = r ? '0 : exp_phase + AW'(STEP);
  endtask

  // Presents n bits back-to-back and checks every cycle of the resulting burst.
  task automatic run_bits(input int n, input logic [7:0] bits, input logic fmin);
    logic                 tx [8];
    logic signed [SW-1:0] raw;
    logic signed [SW-1:0] expd;
    int                   k;
    int                   s;
    for (int i = 0; i < n; i++) begin
`ifdef BPSK_MOD_DIFF_ENCODE_EN
      tx[i]      = bits[i] ^ prev_model;
      prev_model = tx[i];
`else
      tx[i] = bits[i];
`endif
    end
    force_min = fmin;
    for (int c = 0; c <= n * SPS + 2; c++) begin
      k         = (c / SPS > n - 1) ? n - 1 : c / SPS;
      bit_valid = (c <= (n - 1) * SPS);
      bit_in    = bits[k];
      tick();
      chk("angle", 32'(cosine_lu_angle_steps), 32'(exp_phase));
      if (c >= 2 && c < n * SPS + 2) begin
        s    = (c - 2) / SPS;
        raw  = fmin ? C_MIN : lut_f(ph2);
        expd = tx[s] ? ((raw == C_MIN) ? C_MAX : -raw) : raw;
        chk("valid_on", 32'(data_out_valid), 1);
        chk("sample", data_out, expd);
      end else begin
        chk("valid_off", 32'(data_out_valid), 0);
        chk("data_zero", data_out, 0);
      end
      chk("underrun", 32'(underrun), (c == n * SPS) ? 1 : 0);
    end
    bit_valid = 1'b0;
    force_min = 1'b0;
  endtask

  initial begin
    vectors    = 0;
    fails      = 0;
    force_min  = 1'b0;
    prev_model = 1'b0;
    exp_phase  = '0;
    ph1        = '0;
    ph2        = '0;
    rst        = 1'b1;
    bit_valid  = 1'b1;
    bit_in     = 1'b1;

    // Long reset with valid asserted: nothing may be accepted.
    repeat (100) tick();
    chk("rst_data", data_out, 0);
    chk("rst_valid", 32'(data_out_valid), 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_ready", 32'(bit_ready), 0);
    chk("rst_angle", 32'(cosine_lu_angle_steps), 0);

    rst       = 1'b0;
    bit_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_angle", 32'(cosine_lu_angle_steps), 32'(exp_phase));
      chk("idle_valid", 32'(data_out_valid), 0);
      chk("idle_ready", 32'(bit_ready), 1);
    end

    run_bits(1, 8'b0000_0000, 1'b0);
    run_bits(4, 8'b0000_0110, 1'b0);
    run_bits(1, 8'b0000_0001, 1'b1);
    repeat (3) tick();
    run_bits(4, 8'b0000_1011, 1'b0);

    // Reset in the middle of a symbol.
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    tick();
    bit_valid = 1'b0;
    repeat (SPS / 2) tick();
    chk("mid_valid", 32'(data_out_valid), 1);
    rst = 1'b1;
    tick();
    prev_model = 1'b0;
    chk("mid_rst_data", data_out, 0);
    chk("mid_rst_valid", 32'(data_out_valid), 0);
    chk("mid_rst_angle", 32'(cosine_lu_angle_steps), 0);
    chk("mid_rst_ready", 32'(bit_ready), 0);
    chk("mid_rst_underrun", 32'(underrun), 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_valid", 32'(data_out_valid), 0);
      chk("post_rst_underrun", 32'(underrun), 0);
    end
    run_bits(1, 8'b0000_0001, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

`default_nettype wire
